// File: rtl/min_trigger_pkg.sv
// Shared definitions for the minimum-trigger front end: lane geometry,
// trigger state encoding and the amplitude threshold conversion.
package min_trigger_pkg;

    localparam int LANE_WIDTH          = 16;
    localparam int DEFAULT_TDATA_WIDTH = 128;
    localparam int NUM_LANES           = DEFAULT_TDATA_WIDTH / LANE_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } trig_state_t;

    // Convert a percentage of full scale into a sample code, rounding down.
    function automatic int threshold_code(input int threshold, input int res_width);
        longint scaled;
        scaled = longint'(threshold) * (64'sd1 <<< res_width);
        return int'(scaled / 64'sd100);
    endfunction

endpackage

// File: rtl/lane_threshold_cmp.sv
// Combinational amplitude detector: slices every 16-bit lane, takes the
// MSB-justified signed sample and flags a hit when any lane is strictly
// above the threshold code. Negative excursions never hit.
module lane_threshold_cmp
    import min_trigger_pkg::*;
#(
    parameter int TDATA_WIDTH = 128,
    parameter int RES_WIDTH   = 12,
    parameter int THR_CODE    = 409
) (
    input  logic [TDATA_WIDTH-1:0] tdata,
    output logic                   hit
);

    localparam int                 LANES = TDATA_WIDTH / LANE_WIDTH;
    localparam logic signed [31:0] THR_S = THR_CODE;

    logic signed [31:0] sample_ext_s [LANES];
    logic [LANES-1:0]   lane_hit_s;
    // The low-order padding bits below each sample carry no information.
    logic               unused_lsb_s;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [RES_WIDTH-1:0] sample_s;
        assign sample_s        = tdata[LANE_WIDTH*k + LANE_WIDTH - 1 -: RES_WIDTH];
        assign sample_ext_s[k] = $signed({{(32-RES_WIDTH){sample_s[RES_WIDTH-1]}}, sample_s});
        assign lane_hit_s[k]   = (sample_ext_s[k] > THR_S);
    end

    assign hit          = |lane_hit_s;
    assign unused_lsb_s = ^tdata;

endmodule

// File: rtl/min_trigger_gen.sv
// Self-triggering front end between the RF data converter stream and the
// readout interface. Each accepted beat is checked against the amplitude
// threshold; the event FSM produces START_TRG, FINALIZE_TRG and a latched
// TIME_STAMP that leave the block on the same cycle as the forwarded beat.
module min_trigger_gen
    import min_trigger_pkg::*;
#(
    parameter int THRESHOLD            = 10,
    parameter int POST_ACQUI_LEN       = 38,
    parameter int ACQUI_LEN            = 100,
    parameter int HOLDOFF_LEN          = 2,
    parameter int TIME_STAMP_WIDTH     = 16,
    parameter int ADC_RESOLUTION_WIDTH = 12,
    parameter int S_AXIS_TDATA_WIDTH   = 128
) (
    input  logic                          AXIS_ACLK,
    input  logic                          AXIS_ARESETN,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                          S_AXIS_TVALID,
    output logic                          S_AXIS_TREADY,
    output logic [S_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                          M_AXIS_TVALID,
    input  logic                          FIFO_FULL,
    output logic                          START_TRG,
    output logic                          FINALIZE_TRG,
    output logic [TIME_STAMP_WIDTH-1:0]   TIME_STAMP,
    output logic [31:0]                   TRG_CNT
);

    localparam int THR_CODE = threshold_code(THRESHOLD, ADC_RESOLUTION_WIDTH);
    localparam int BEAT_W   = $clog2(ACQUI_LEN + 1);
    localparam int POST_W   = $clog2(POST_ACQUI_LEN + 1);
    localparam int HOLD_W   = $clog2(HOLDOFF_LEN + 1);

    localparam logic [BEAT_W-1:0] BEAT_ONE   = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] ACQUI_LAST = BEAT_W'(ACQUI_LEN);
    localparam logic [POST_W-1:0] POST_ONE   = POST_W'(1);
    localparam logic [POST_W-1:0] POST_LAST  = POST_W'(POST_ACQUI_LEN);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLDOFF_LEN);

    trig_state_t                   state_r, state_nxt_s;
    logic [BEAT_W-1:0]             beat_cnt_r, beat_nxt_s, beat_inc_s;
    logic [POST_W-1:0]             post_cnt_r, post_nxt_s, post_inc_s;
    logic [HOLD_W-1:0]             hold_cnt_r, hold_nxt_s;
    logic [TIME_STAMP_WIDTH-1:0]   ts_cnt_r, ts_latch_r, ts_nxt_s;
    logic [31:0]                   trg_cnt_r, trg_nxt_s;
    logic                          start_r, start_nxt_s;
    logic                          fin_r, fin_nxt_s;
    logic                          tready_r, mvalid_r;
    logic [S_AXIS_TDATA_WIDTH-1:0] mdata_r;
    logic                          accept_s;
    logic                          hit_s;

    assign accept_s = S_AXIS_TVALID & tready_r;

    lane_threshold_cmp #(
        .TDATA_WIDTH (S_AXIS_TDATA_WIDTH),
        .RES_WIDTH   (ADC_RESOLUTION_WIDTH),
        .THR_CODE    (THR_CODE)
    ) u_cmp (
        .tdata (S_AXIS_TDATA),
        .hit   (hit_s)
    );

    // Event FSM next-state, counter updates and per-beat flag values.
    always_comb begin
        state_nxt_s = state_r;
        beat_nxt_s  = beat_cnt_r;
        post_nxt_s  = post_cnt_r;
        hold_nxt_s  = hold_cnt_r;
        start_nxt_s = start_r;
        fin_nxt_s   = 1'b0;
        ts_nxt_s    = ts_latch_r;
        trg_nxt_s   = trg_cnt_r;
        beat_inc_s  = beat_cnt_r + BEAT_ONE;
        post_inc_s  = hit_s ? {POST_W{1'b0}} : (post_cnt_r + POST_ONE);

        if (accept_s) begin
            case (state_r)
                IDLE: begin
                    if (hit_s && !FIFO_FULL) begin
                        start_nxt_s = 1'b1;
                        ts_nxt_s    = ts_cnt_r;
                        trg_nxt_s   = trg_cnt_r + 32'd1;
                        beat_nxt_s  = BEAT_ONE;
                        post_nxt_s  = {POST_W{1'b0}};
                        // A one-beat event closes on its own first beat.
                        if (BEAT_ONE == ACQUI_LAST) begin
                            fin_nxt_s   = 1'b1;
                            hold_nxt_s  = {HOLD_W{1'b0}};
                            state_nxt_s = HOLDOFF;
                        end else begin
                            state_nxt_s = ACTIVE;
                        end
                    end else begin
                        start_nxt_s = 1'b0;
                    end
                end
                ACTIVE: begin
                    start_nxt_s = 1'b1;
                    beat_nxt_s  = beat_inc_s;
                    post_nxt_s  = post_inc_s;
                    if ((post_inc_s == POST_LAST) || (beat_inc_s == ACQUI_LAST) || FIFO_FULL) begin
                        fin_nxt_s   = 1'b1;
                        hold_nxt_s  = {HOLD_W{1'b0}};
                        state_nxt_s = HOLDOFF;
                    end else begin
                        state_nxt_s = ACTIVE;
                    end
                end
                HOLDOFF: begin
                    start_nxt_s = 1'b0;
                    if ((hold_cnt_r + HOLD_ONE) == HOLD_LAST) begin
                        hold_nxt_s  = {HOLD_W{1'b0}};
                        state_nxt_s = IDLE;
                    end else begin
                        hold_nxt_s  = hold_cnt_r + HOLD_ONE;
                    end
                end
                default: begin
                    start_nxt_s = 1'b0;
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Event FSM state, counters and registered trigger outputs.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_r    <= IDLE;
            beat_cnt_r <= {BEAT_W{1'b0}};
            post_cnt_r <= {POST_W{1'b0}};
            hold_cnt_r <= {HOLD_W{1'b0}};
            start_r    <= 1'b0;
            fin_r      <= 1'b0;
            ts_latch_r <= {TIME_STAMP_WIDTH{1'b0}};
            trg_cnt_r  <= 32'd0;
        end else begin
            state_r    <= state_nxt_s;
            beat_cnt_r <= beat_nxt_s;
            post_cnt_r <= post_nxt_s;
            hold_cnt_r <= hold_nxt_s;
            start_r    <= start_nxt_s;
            fin_r      <= fin_nxt_s;
            ts_latch_r <= ts_nxt_s;
            trg_cnt_r  <= trg_nxt_s;
        end
    end

    // Stream side: ready after reset, one-stage data forward, beat timestamp.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            tready_r <= 1'b0;
            mvalid_r <= 1'b0;
            mdata_r  <= {S_AXIS_TDATA_WIDTH{1'b0}};
            ts_cnt_r <= {TIME_STAMP_WIDTH{1'b0}};
        end else begin
            tready_r <= 1'b1;
            mvalid_r <= accept_s;
            if (accept_s) begin
                mdata_r  <= S_AXIS_TDATA;
                ts_cnt_r <= ts_cnt_r + {{(TIME_STAMP_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                mdata_r  <= mdata_r;
                ts_cnt_r <= ts_cnt_r;
            end
        end
    end

    assign S_AXIS_TREADY = tready_r;
    assign M_AXIS_TVALID = mvalid_r;
    assign M_AXIS_TDATA  = mdata_r;
    assign START_TRG     = start_r;
    assign FINALIZE_TRG  = fin_r;
    assign TIME_STAMP    = ts_latch_r;
    assign TRG_CNT       = trg_cnt_r;

endmodule

// File: tb/tb_min_trigger_gen.sv
// Scoreboard bench for min_trigger_gen: a behavioural event model predicts
// every forwarded beat, expectations are queued on accept and compared when
// the DUT presents the beat; event statistics back the directed scenarios.
module tb_min_trigger_gen;

    localparam int THR_EXP = 10 * 4096 / 100;
    localparam int POST    = 38;
    localparam int ACQ     = 100;
    localparam int HOLD    = 2;

    typedef struct {
        logic [127:0] data;
        logic         start;
        logic         fin;
        logic [15:0]  ts;
        logic [31:0]  trg;
    } exp_t;

    logic         aclk      = 1'b0;
    logic         rst_n     = 1'b0;
    logic [127:0] s_tdata   = '0;
    logic         s_tvalid  = 1'b0;
    logic         fifo_full = 1'b0;
    logic         s_tready;
    logic [127:0] m_tdata;
    logic         m_tvalid;
    logic         start_trg;
    logic         fin_trg;
    logic [15:0]  time_stamp;
    logic [31:0]  trg_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t exp_q[$];

    // behavioural model state
    logic m_ready;
    int   m_state;
    int   m_len, m_quiet, m_hold_left;
    int   m_ts_cnt, m_ts_lat, m_trg;
    logic m_start;

    // event statistics taken from DUT output beats
    int   fin_len_q[$];
    int   start_ts_q[$];
    int   gap_q[$];
    int   st_len, st_gap;
    logic st_in_evt;

    min_trigger_gen #(
        .THRESHOLD            (10),
        .POST_ACQUI_LEN       (POST),
        .ACQUI_LEN            (ACQ),
        .HOLDOFF_LEN          (HOLD),
        .TIME_STAMP_WIDTH     (16),
        .ADC_RESOLUTION_WIDTH (12),
        .S_AXIS_TDATA_WIDTH   (128)
    ) dut (
        .AXIS_ACLK     (aclk),
        .AXIS_ARESETN  (rst_n),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TREADY (s_tready),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TVALID (m_tvalid),
        .FIFO_FULL     (fifo_full),
        .START_TRG     (start_trg),
        .FINALIZE_TRG  (fin_trg),
        .TIME_STAMP    (time_stamp),
        .TRG_CNT       (trg_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] lane_beat(input int lane, input int sample);
        logic [127:0] d;
        d = '0;
        d[16*lane +: 16] = {12'(sample), 4'h0};
        return d;
    endfunction

    function automatic logic model_hit(input logic [127:0] d);
        int s;
        for (int k = 0; k < 8; k++) begin
            s = int'(d[16*k+4 +: 12]);
            if (s >= 2048) s = s - 4096;
            if (s > THR_EXP) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_ready = 1'b0; m_state = 0; m_len = 0; m_quiet = 0; m_hold_left = 0;
        m_ts_cnt = 0; m_ts_lat = 0; m_trg = 0; m_start = 1'b0;
        exp_q.delete();
        st_in_evt = 1'b0; st_len = 0; st_gap = 0;
    endtask

    task automatic clear_stats();
        fin_len_q.delete(); start_ts_q.delete(); gap_q.delete();
    endtask

    // one accepted beat through the event model; returns the finalize flag
    task automatic model_beat(input logic h, input logic f, output logic fin);
        fin = 1'b0;
        if (m_state == 0) begin
            if (h && !f) begin
                m_start = 1'b1; m_ts_lat = m_ts_cnt; m_trg = m_trg + 1;
                m_len = 1; m_quiet = 0; m_state = 1;
            end else begin
                m_start = 1'b0;
            end
        end else if (m_state == 1) begin
            m_start = 1'b1;
            m_len   = m_len + 1;
            m_quiet = h ? 0 : m_quiet + 1;
            if (m_quiet >= POST || m_len >= ACQ || f) begin
                fin = 1'b1; m_state = 2; m_hold_left = HOLD;
            end
        end else begin
            m_start = 1'b0;
            m_hold_left = m_hold_left - 1;
            if (m_hold_left == 0) m_state = 0;
        end
        m_ts_cnt = (m_ts_cnt + 1) % 65536;
    endtask

    task automatic update_stats();
        if (start_trg) begin
            if (!st_in_evt) begin
                start_ts_q.push_back(int'(time_stamp));
                gap_q.push_back(st_gap);
                st_len = 0;
                st_in_evt = 1'b1;
            end
            st_len = st_len + 1;
            st_gap = 0;
        end else begin
            st_gap = st_gap + 1;
        end
        if (fin_trg) begin
            fin_len_q.push_back(st_len);
            st_in_evt = 1'b0;
        end
    endtask

    task automatic check_outputs(input logic acc);
        exp_t e;
        check_eq("tready", 128'(s_tready), 128'(m_ready));
        check_eq("tvalid", 128'(m_tvalid), 128'(acc));
        if (m_tvalid) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 128'(exp_q.size()), 128'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("tdata", m_tdata, e.data);
                check_eq("start", 128'(start_trg), 128'(e.start));
                check_eq("finalize", 128'(fin_trg), 128'(e.fin));
                check_eq("time_stamp", 128'(time_stamp), 128'(e.ts));
                check_eq("trg_cnt", 128'(trg_cnt), 128'(e.trg));
            end
            update_stats();
        end else begin
            check_eq("fin_gap", 128'(fin_trg), 128'd0);
            check_eq("start_hold", 128'(start_trg), 128'(m_start));
            check_eq("ts_hold", 128'(time_stamp), 128'(16'(m_ts_lat)));
            check_eq("trg_hold", 128'(trg_cnt), 128'(32'(m_trg)));
        end
    endtask

    // present one cycle of stimulus, predict, then compare on the falling edge
    task automatic step(input logic [127:0] d, input logic v, input logic f);
        logic acc, fin_e;
        exp_t e;
        s_tdata = d; s_tvalid = v; fifo_full = f;
        @(posedge aclk);
        acc = rst_n && v && m_ready;
        if (acc) begin
            model_beat(model_hit(d), f, fin_e);
            e.data = d; e.start = m_start; e.fin = fin_e;
            e.ts = 16'(m_ts_lat); e.trg = 32'(m_trg);
            exp_q.push_back(e);
        end
        m_ready = rst_n;
        @(negedge aclk);
        check_outputs(acc);
    endtask

    task automatic idle_beats(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b1, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tready"}, 128'(s_tready), 128'd0);
        check_eq({tag, "_tvalid"}, 128'(m_tvalid), 128'd0);
        check_eq({tag, "_tdata"}, m_tdata, 128'd0);
        check_eq({tag, "_start"}, 128'(start_trg), 128'd0);
        check_eq({tag, "_fin"}, 128'(fin_trg), 128'd0);
        check_eq({tag, "_ts"}, 128'(time_stamp), 128'd0);
        check_eq({tag, "_trg"}, 128'(trg_cnt), 128'd0);
    endtask

    initial begin
        model_reset();
        clear_stats();

        // reset and release
        repeat (2) @(negedge aclk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step('0, 1'b0, 1'b0);
        check_eq("tready_release", 128'(s_tready), 128'd1);

        // single pulse on beat with timestamp 10
        clear_stats();
        idle_beats(10);
        step(lane_beat(3, 500), 1'b1, 1'b0);
        idle_beats(50);
        check_eq("sp_events", 128'(start_ts_q.size()), 128'd1);
        check_eq("sp_ts", 128'(start_ts_q[0]), 128'd10);
        check_eq("sp_len", 128'(fin_len_q[0]), 128'd39);
        check_eq("sp_trg", 128'(trg_cnt), 128'd1);

        // continuous hit: capped at ACQ beats, restart after holdoff
        clear_stats();
        for (int i = 0; i < 205; i++) step(lane_beat(0, 1000), 1'b1, 1'b0);
        idle_beats(50);
        check_eq("ch_len0", 128'(fin_len_q[0]), 128'd100);
        check_eq("ch_gap", 128'(gap_q[1]), 128'd2);
        check_eq("ch_ts_step", 128'(16'(start_ts_q[1] - start_ts_q[0])), 128'd102);

        // FIFO full ends an event and blocks new ones
        clear_stats();
        step(lane_beat(1, 600), 1'b1, 1'b0);
        idle_beats(18);
        step('0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(lane_beat(2, 700), 1'b1, 1'b1);
        idle_beats(3);
        step(lane_beat(2, 700), 1'b1, 1'b0);
        idle_beats(45);
        check_eq("ff_events", 128'(start_ts_q.size()), 128'd2);
        check_eq("ff_len0", 128'(fin_len_q[0]), 128'd20);
        check_eq("ff_ts_step", 128'(16'(start_ts_q[1] - start_ts_q[0])), 128'd33);

        // TVALID gaps inside an event
        clear_stats();
        step(lane_beat(6, 800), 1'b1, 1'b0);
        idle_beats(10);
        for (int i = 0; i < 5; i++) step(lane_beat(6, 800), 1'b0, 1'b0);
        check_eq("gap_start_held", 128'(start_trg), 128'd1);
        idle_beats(40);
        check_eq("gap_len", 128'(fin_len_q[0]), 128'd39);

        // threshold edges
        clear_stats();
        step(lane_beat(5, 409), 1'b1, 1'b0);
        idle_beats(5);
        step(lane_beat(4, -500), 1'b1, 1'b0);
        idle_beats(5);
        check_eq("thr_no_trig", 128'(start_ts_q.size()), 128'd0);
        step(lane_beat(5, 410), 1'b1, 1'b0);
        idle_beats(45);
        check_eq("thr_trig", 128'(start_ts_q.size()), 128'd1);

        // randomised stream against the model
        for (int i = 0; i < 400; i++) begin
            logic [127:0] d;
            for (int k = 0; k < 8; k++)
                d[16*k +: 16] = {12'($urandom_range(0, 800)) - 12'd400, 4'($urandom_range(0, 15))};
            if ($urandom_range(0, 11) == 0)
                d[16*$urandom_range(0, 7) +: 16] = {12'($urandom_range(300, 700)), 4'h5};
            step(d, ($urandom_range(0, 5) != 0), ($urandom_range(0, 30) == 0));
        end
        idle_beats(60);

        // reset in the middle of an event
        step(lane_beat(7, 900), 1'b1, 1'b0);
        idle_beats(5);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        step('0, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);
        rst_n = 1'b1;
        step('0, 1'b0, 1'b0);
        check_eq("rel_tready", 128'(s_tready), 128'd1);
        step(lane_beat(0, 450), 1'b1, 1'b0);
        check_eq("post_rst_trg", 128'(trg_cnt), 128'd1);
        check_eq("post_rst_ts", 128'(time_stamp), 128'd0);
        idle_beats(45);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
